// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with status flags; result appears one edge after acceptance.
// Valid/ready stream, one beat per cycle; each stage holds its data while the stage downstream is stalled.
module cla_add_pipe #(
   parameter int WIDTH = 32,
   parameter int GROUP = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cIn,
   input  logic             sub,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] s,
   output logic             cOut,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = WIDTH / GROUP;

   logic             v1, v2;
   logic             adv1, adv2;

   logic [WIDTH-1:0] y_eff, g_in, p_in;
   logic [NG-1:0]    gg_in, pg_in;
   logic             c0_in;

   logic [WIDTH-1:0] g1, p1;
   logic [NG-1:0]    gg1, pg1;
   logic             c01;

   logic [NG:0]      cg;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_n;

   assign adv2     = !v2 || outReady;
   assign adv1     = !v1 || adv2;
   assign inReady  = adv1;
   assign outValid = v2;

   always_comb begin
      logic gacc, pacc;
      y_eff = sub ? ~y : y;
      c0_in = sub ? 1'b1 : cIn;
      g_in  = x & y_eff;
      p_in  = x ^ y_eff;
      gg_in = '0;
      pg_in = '0;
      for (int k = 0; k < NG; k++) begin
         gacc = 1'b0;
         pacc = 1'b1;
         for (int b = 0; b < GROUP; b++) begin
            gacc = g_in[k*GROUP+b] | (p_in[k*GROUP+b] & gacc);
            pacc = pacc & p_in[k*GROUP+b];
         end
         gg_in[k] = gacc;
         pg_in[k] = pacc;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         v1  <= 1'b0;
         g1  <= '0;
         p1  <= '0;
         gg1 <= '0;
         pg1 <= '0;
         c01 <= 1'b0;
      end else if (adv1) begin
         v1 <= inValid;
         if (inValid) begin
            g1  <= g_in;
            p1  <= p_in;
            gg1 <= gg_in;
            pg1 <= pg_in;
            c01 <= c0_in;
         end
      end
   end

   // Each group carry is a flat sum of products over all lower groups, so no carry ripples between groups.
   always_comb begin
      logic term, prod, cr;
      cg    = '0;
      c     = '0;
      cg[0] = c01;
      for (int k = 0; k < NG; k++) begin
         term = c01;
         for (int m = 0; m <= k; m++) term = term & pg1[m];
         for (int j = 0; j <= k; j++) begin
            prod = gg1[j];
            for (int m = j + 1; m <= k; m++) prod = prod & pg1[m];
            term = term | prod;
         end
         cg[k+1] = term;
      end
      for (int k = 0; k < NG; k++) begin
         cr = cg[k];
         for (int b = 0; b < GROUP; b++) begin
            c[k*GROUP+b] = cr;
            cr = g1[k*GROUP+b] | (p1[k*GROUP+b] & cr);
         end
      end
      c[WIDTH] = cg[NG];
      sum_n    = p1 ^ c[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         v2   <= 1'b0;
         s    <= '0;
         cOut <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            s    <= sum_n;
            cOut <= c[WIDTH];
            ovf  <= c[WIDTH] ^ c[WIDTH-1];
            zero <= (sum_n == '0);
         end
      end
   end

endmodule

// File: tb/tb_cla_add_pipe.sv
// Bench for cla_add_pipe: directed vectors, streaming backpressure, mid-flight reset, and a randomised 16-bit run.
module tb_cla_add_pipe;

   logic        clk = 1'b0;
   logic        rstN;
   logic        inValid, inReady, cIn, sub, outValid, outReady, cOut, ovf, zero;
   logic [31:0] x, y, s;

   logic        r_inValid, r_inReady, r_cIn, r_sub, r_outValid, r_outReady, r_cOut, r_ovf, r_zero;
   logic [15:0] r_x, r_y, r_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cla_add_pipe #(.WIDTH(32), .GROUP(8)) dut (
      .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .x(x), .y(y),
      .cIn(cIn), .sub(sub), .outValid(outValid), .outReady(outReady), .s(s),
      .cOut(cOut), .ovf(ovf), .zero(zero));

   cla_add_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
      .clk(clk), .rstN(rstN), .inValid(r_inValid), .inReady(r_inReady), .x(r_x), .y(r_y),
      .cIn(r_cIn), .sub(r_sub), .outValid(r_outValid), .outReady(r_outReady), .s(r_s),
      .cOut(r_cOut), .ovf(r_ovf), .zero(r_zero));

   typedef struct {
      string       name;
      logic [31:0] x;
      logic [31:0] y;
      logic        cin;
      logic        sub;
      logic [31:0] es;
      logic        ec;
      logic        eo;
      logic        ez;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sends one beat into an empty pipe and checks latency plus all result fields.
   task automatic send_wait(input vec_t v);
      int lat;
      bit got;
      @(negedge clk);
      inValid = 1'b1; x = v.x; y = v.y; cIn = v.cin; sub = v.sub; outReady = 1'b1;
      #1;
      chk({v.name, "_inReady"}, inReady, 1'b1);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      got = 1'b0;
      lat = 0;
      for (int n = 0; n < 8 && !got; n++) begin
         #1;
         if (outValid) begin
            got = 1'b1;
            lat = n;
         end else begin
            @(negedge clk);
         end
      end
      chk({v.name, "_outValid"}, got, 1'b1);
      chk({v.name, "_latency"}, lat, 1);
      chk({v.name, "_s"}, s, v.es);
      chk({v.name, "_cOut"}, cOut, v.ec);
      chk({v.name, "_ovf"}, ovf, v.eo);
      chk({v.name, "_zero"}, zero, v.ez);
   endtask

   task automatic run_stream();
      int sent = 0, got = 0, cnt = 0;
      bit acc, take, stalled = 1'b0;
      logic [31:0] held = '0;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         @(negedge clk);
         outReady = (cyc % 2 == 0);
         inValid  = (sent < 8);
         x = sent; y = sent << 4; cIn = 1'b0; sub = 1'b0;
         #1;
         if (stalled) begin
            chk("stream_hold_valid", outValid, 1'b1);
            chk("stream_hold_s", s, held);
         end
         chk("stream_inReady", inReady, !(cnt == 2 && !outReady));
         acc  = inValid && inReady;
         take = outValid && outReady;
         if (take) begin
            chk("stream_s", s, got * 17);
            got++;
         end
         stalled = outValid && !outReady;
         held    = s;
         if (acc) sent++;
         cnt = cnt + int'(acc) - int'(take);
      end
      chk("stream_count", got, 8);
      @(negedge clk);
      inValid = 1'b0; outReady = 1'b1;
      #1;
      chk("stream_drained", outValid, 1'b0);
   endtask

   task automatic run_reset_mid();
      vec_t v;
      @(negedge clk);
      outReady = 1'b0; inValid = 1'b1; x = 32'd1; y = 32'd2; cIn = 1'b0; sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      x = 32'd3; y = 32'd4;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      #1;
      chk("rst_mid_before", outValid, 1'b1);
      #2 rstN = 1'b0;
      #1;
      chk("rst_mid_outValid", outValid, 1'b0);
      chk("rst_mid_inReady", inReady, 1'b1);
      chk("rst_mid_s", s, 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      outReady = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         #1;
         chk("rst_mid_no_stale", outValid, 1'b0);
      end
      v = '{"rst_first", 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0, 1'b0};
      send_wait(v);
   endtask

   task automatic run_random(input int nbeats);
      logic [18:0] q[$];
      logic [18:0] exp_r;
      logic [15:0] ye, sm;
      logic [16:0] full;
      int sent = 0, got = 0;
      bit pend = 1'b0;
      for (int cyc = 0; cyc < 60000 && got < nbeats; cyc++) begin
         @(negedge clk);
         r_outReady = ($urandom_range(3) != 0);
         if (!pend && sent < nbeats && $urandom_range(3) != 0) begin
            r_x   = 16'($urandom);
            r_y   = 16'($urandom);
            r_cIn = 1'($urandom);
            r_sub = 1'($urandom);
            pend  = 1'b1;
         end
         r_inValid = pend;
         #1;
         if (r_outValid && r_outReady) begin
            if (q.size() == 0) begin
               chk("rand_unexpected", 1'b1, 1'b0);
            end else begin
               exp_r = q.pop_front();
               chk("rand_result", {r_s, r_cOut, r_ovf, r_zero}, exp_r);
            end
            got++;
         end
         if (pend && r_inReady) begin
            ye   = r_sub ? ~r_y : r_y;
            full = {1'b0, r_x} + {1'b0, ye} + (r_sub ? 17'd1 : {16'd0, r_cIn});
            sm   = full[15:0];
            q.push_back({sm, full[16], (r_x[15] == ye[15]) && (sm[15] != r_x[15]), sm == 16'd0});
            pend = 1'b0;
            sent++;
         end
      end
      chk("rand_count", got, nbeats);
      r_inValid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{"all_prop",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{"pos_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{"neg_ovf",    32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vecs[3]  = '{"sub_5_7",    32'd5,        32'd7,        1'bx, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"sub_7_5",    32'd7,        32'd5,        1'bx, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{"sub_ovf",    32'h80000000, 32'd1,        1'bx, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{"add_cin",    32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h21436588, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"sub_cin_ig", 32'd0,        32'd0,        1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{"zero_cin",   32'd0,        32'd0,        1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"sub_0_1",    32'd0,        32'd1,        1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"grp_carry",  32'h00FF00FF, 32'h00000001, 1'b0, 1'b0, 32'h00FF0100, 1'b0, 1'b0, 1'b0};

      rstN = 1'b0;
      inValid = 1'b0; x = '0; y = '0; cIn = 1'b0; sub = 1'b0; outReady = 1'b1;
      r_inValid = 1'b0; r_x = '0; r_y = '0; r_cIn = 1'b0; r_sub = 1'b0; r_outReady = 1'b1;

      #12;
      chk("in_reset_outValid", outValid, 1'b0);
      chk("in_reset_inReady", inReady, 1'b1);
      @(negedge clk);
      rstN = 1'b1;
      #1;
      chk("reset_outValid", outValid, 1'b0);
      chk("reset_inReady", inReady, 1'b1);
      chk("reset_s", s, 32'd0);
      chk("reset_flags", {cOut, ovf, zero}, 3'b000);

      for (int i = 0; i < 11; i++) send_wait(vecs[i]);

      run_stream();
      run_reset_mid();
      run_random(10000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
